mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//   Parametrised iterative multiply/divide unit for the pipelined MIPS EX stage, next to alu.
//   Executes MULT/MULTU/DIV/DIVU over multiple cycles into architectural HI/LO registers.
//   Also executes MTHI/MTLO writes; HI/LO are read continuously for MFHI/MFLO.
//   Uses a valid/ready handshake toward the pipeline and a flush input for exception squash.
// PARAMETERS
//   WIDTH     32  operand and HI/LO width; even, >= 4
//   FAST_MUL  0   0: multiply iterative (WIDTH steps); 1: multiply in one step (combinational product)
// PORTS
//   clk          in   1      sole clock, rising edge
//   reset        in   1      synchronous, active-high
//   in_valid     in   1      op/a/b valid this cycle
//   in_ready     out  1      unit can accept an op (= !busy)
//   op           in   3      mdu_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6,7 reserved
//   a            in   WIDTH  multiplicand / dividend / MT source
//   b            in   WIDTH  multiplier / divisor
//   flush        in   1      abort in-flight op; HI/LO unchanged
//   busy         out  1      multi-cycle op in flight
//   done         out  1      1-cycle pulse: HI/LO just updated by MULT*/DIV*
//   div_by_zero  out  1      valid with done; set for DIV/DIVU with b==0
//   hi           out  WIDTH  HI register
//   lo           out  WIDTH  LO register
// BEHAVIOUR
//   Reset: hi=lo=0, busy=0, done=0, div_by_zero=0, in_ready=1. Reset mid-op aborts with no done.
//   Accept on rising edge E0 when in_valid && in_ready && !flush. flush wins over in_valid.
//   Reserved ops are accepted and dropped: no state change, no done.
//   MTHI/MTLO: hi (resp. lo) <= a at E0. No busy, no done. A new op may follow next cycle.
//   MULT*/DIV* timing:
//     - FSM IDLE -> RUN at E0. Operands are latched at E0.
//     - Signed ops latch magnitudes plus result sign(s).
//     - RUN performs one step per edge E1..E_WIDTH.
//     - RUN -> FIX at E_WIDTH. FIX applies sign correction and writes hi/lo at E_WIDTH+1.
//     - FIX -> IDLE at E_WIDTH+1. done=1 for exactly the cycle after E_WIDTH+1.
//     - in_ready=1 in that same cycle, so back-to-back issue is legal.
//   FAST_MUL=1: multiply uses RUN for a single edge (E1). Commit at E2. Divide is unaffected.
//   Multiply: {hi,lo} = full 2*WIDTH product. Signed for MULT, unsigned for MULTU.
//     - Step: shift-add on a 2*WIDTH accumulator.
//   Divide: restoring, one quotient bit per step. lo = quotient, hi = remainder.
//     - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
//     - b==0: lo = all ones, hi = a (as latched); div_by_zero=1 with done. Timing unchanged.
//     - DIV MIN / -1: lo = MIN, hi = 0, div_by_zero=0 (natural wrap, no trap).
//   flush while busy: FSM -> IDLE on that edge. busy=0 and in_ready=1 next cycle.
//     - hi/lo keep pre-op values; no done.
//   flush on the FIX cycle also suppresses the commit.
//   busy == (state != IDLE); in_ready == !busy. Both are registered, so in_ready is glitch-free.
//   Arithmetic is modulo 2^WIDTH per register; no X propagation from unused op bits.
// STRUCTURE
//   mdu_pkg: mdu_op_t enum, state_t {IDLE, RUN, FIX}, is_mul()/is_signed() helper functions.
//   Sub-module mdu_step_core (combinational):
//     - Performs one shift-add or restore-subtract step on {acc, quot/mplr}.
//   Top level holds the FSM, step counter ($clog2(WIDTH)+1 bits), operand/sign latches and HI/LO.
// TESTING  (WIDTH=32 unless noted; E0 = accept edge)
//   MULT a=FFFFFFFE b=00000003 -> hi=FFFFFFFF lo=FFFFFFFA at E33; done 1 cycle; busy E0..E33.
//   DIVU a=100 b=7 -> lo=14 hi=2.
//   DIV a=FFFFFFF9 (-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF; back-to-back issue on the done cycle.
//   DIV a=5 b=0 -> lo=FFFFFFFF hi=5 div_by_zero=1.
//   DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0 div_by_zero=0.
//   Sequence MTHI a=AAAA5555, then MULTU, then MTLO while busy:
//     - MTLO is not accepted (in_ready=0).
//     - flush at E10 -> busy=0 next cycle, hi=AAAA5555 unchanged, no done.
//   reset at E15 of DIVU -> hi=lo=0, done=0, in_ready=1 next cycle.
//   FAST_MUL=1, MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE lo=00000001, done after E2.
//   Random checker: reference model of 500 mixed ops with random flush -> zero mismatches.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Op encoding, FSM states and small op-class decoders.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_step_core.sv
// One iteration of shift-add multiply or restoring divide.
// Ports: is_mul_i, acc_i/lo_i (state), opb_i (mcand/divisor) -> acc_o/lo_o.
module mdu_step_core #(
  parameter int WIDTH = 32
) (
  input  logic             is_mul_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
    sh   = {acc_i, lo_i[WIDTH-1]};
    diff = sh - {1'b0, opb_i};
    if (is_mul_i) begin
      // add-then-shift right; multiplier bits retire out of lo
      acc_o = sum[WIDTH:1];
      lo_o  = {sum[0], lo_i[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_o = diff[WIDTH-1:0];
      lo_o  = {lo_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = sh[WIDTH-1:0];
      lo_o  = {lo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO.
// Ports: clk, reset, in_valid/in_ready, op, a, b, flush, busy, done, div_by_zero, hi, lo.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             mul_q;
  logic             neg_q;
  logic             neg_r_q;
  logic             dbz_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mlo_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dbz_o_q;
  logic             busy_q;
  logic             ready_q;

  logic             accept;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [2*WIDTH-1:0] fprod;
  logic [2*WIDTH-1:0] mres;
  logic [WIDTH-1:0] qres;
  logic [WIDTH-1:0] rres;

  assign accept = in_valid && ready_q && !flush;
  assign sa     = is_signed(op) && a[WIDTH-1];
  assign sb     = is_signed(op) && b[WIDTH-1];
  assign mag_a  = sa ? -a : a;
  assign mag_b  = sb ? -b : b;

  assign fprod = {{WIDTH{1'b0}}, opb_q} * {{WIDTH{1'b0}}, mlo_q};
  assign mres  = neg_q ? -{acc_q, mlo_q} : {acc_q, mlo_q};
  assign qres  = neg_q ? -mlo_q : mlo_q;
  assign rres  = neg_r_q ? -acc_q : acc_q;

  mdu_step_core #(.WIDTH(WIDTH)) u_step (
    .is_mul_i (mul_q),
    .acc_i    (acc_q),
    .lo_i     (mlo_q),
    .opb_i    (opb_q),
    .acc_o    (acc_nx),
    .lo_o     (lo_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      dbz_q   <= 1'b0;
      acc_q   <= '0;
      mlo_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_o_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q  <= 1'b0;
      dbz_o_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MTHI) begin
              hi_q <= a;
            end else if (op == OP_MTLO) begin
              lo_q <= a;
            end else if (!op[2]) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
              cnt_q   <= '0;
              mul_q   <= is_mul(op);
              neg_q   <= sa ^ sb;
              neg_r_q <= sa;
              dbz_q   <= !is_mul(op) && (b == '0);
              acc_q   <= '0;
              // multiplier / dividend bits live in the low half
              mlo_q   <= is_mul(op) ? mag_b : mag_a;
              opb_q   <= is_mul(op) ? mag_a : mag_b;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else if (FAST_MUL && mul_q) begin
            {acc_q, mlo_q} <= fprod;
            state_q        <= S_FIX;
          end else begin
            acc_q <= acc_nx;
            mlo_q <= lo_nx;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          if (!flush) begin
            done_q <= 1'b1;
            if (mul_q) begin
              {hi_q, lo_q} <= mres;
            end else begin
              // remainder of |a|/0 is |a|, so sign fix restores a
              hi_q    <= rres;
              lo_q    <= dbz_q ? '1 : qres;
              dbz_o_q <= dbz_q;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_o_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
